// File: rtl/ntt_sdf_unload_if.sv
// Handshake/bus bundle between the last SDF NTT stage, the unload buffer and
// the downstream consumer of natural-order coefficients.
interface ntt_sdf_unload_if #(
  parameter int LOGQ = 32,
  parameter int LOGN = 8
);
  logic            in_start;
  logic [LOGQ-1:0] in_data;
  logic            out_ready;
  logic            out_valid;
  logic [LOGQ-1:0] out_data;
  logic [LOGN-1:0] out_idx;
  logic            out_last;
  logic            busy;
  logic            overflow;

  // Unload buffer side
  modport slave (
    input  in_start, in_data, out_ready,
    output out_valid, out_data, out_idx, out_last, busy, overflow
  );

  // Pipeline / consumer side
  modport master (
    output in_start, in_data, out_ready,
    input  out_valid, out_data, out_idx, out_last, busy, overflow
  );
endinterface

// File: rtl/ntt_sdf_unload.sv
// Ping-pong capture of the SDF NTT output stream with optional bit-reversed
// write addressing, replayed in natural order through a 2-entry skid buffer.
module ntt_sdf_unload #(
  parameter int LOGQ   = 32,
  parameter int LOGN   = 8,
  parameter int BITREV = 1
) (
  input  logic clk,
  input  logic rst,
  ntt_sdf_unload_if.slave bus
);
  localparam int              N    = 1 << LOGN;
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  typedef enum logic { W_IDLE, W_CAPT } w_state_t;
  typedef enum logic { R_IDLE, R_DRAIN } r_state_t;

  // Both banks live in one simple dual-port array; the bank is the address MSB.
  logic [LOGQ-1:0] mem [0:2*N-1];

  w_state_t        w_state;
  logic [LOGN-1:0] wcnt;
  logic            wbank;
  logic [1:0]      bank_full;
  logic [1:0]      issued;      // every read of this full bank has been issued
  logic            old_bank;    // bank that filled first when both are full
  logic            overflow_reg;

  r_state_t        r_state;
  logic [LOGN-1:0] raddr;
  logic            rbank;

  // q_* is the RAM output register, s_* the skid entry (always the older word).
  logic            q_valid, s_valid;
  logic [LOGQ-1:0] q_data, s_data;
  logic [LOGN-1:0] q_idx, s_idx;
  logic            q_bank, s_bank;

  // Write-side address generation
  logic [1:0]      free_banks;
  logic            new_bank, start_ok, we, wbank_cur;
  logic [LOGN-1:0] wcnt_cur, wcnt_rev, wpos;

  assign free_banks = ~bank_full;
  assign new_bank   = free_banks[0] ? 1'b0 : 1'b1;
  assign start_ok   = (w_state == W_IDLE) && bus.in_start && (free_banks != 2'b00);
  assign we         = start_ok || (w_state == W_CAPT);
  assign wbank_cur  = (w_state == W_IDLE) ? new_bank : wbank;
  assign wcnt_cur   = (w_state == W_IDLE) ? '0 : wcnt;

  for (genvar gi = 0; gi < LOGN; gi++) begin : g_rev
    assign wcnt_rev[gi] = wcnt_cur[LOGN-1-gi];
  end

  assign wpos = (BITREV != 0) ? wcnt_rev : wcnt_cur;

  // Read side: head of the two-deep output queue and read issue control
  logic            head_valid, head_bank, pop, pop_last, can_issue, re, pick;
  logic            rd_bank, issue_done, s_keep, q_keep;
  logic [LOGQ-1:0] head_data;
  logic [LOGN-1:0] head_idx, rd_idx;
  logic [1:0]      avail;

  assign head_valid = s_valid | q_valid;
  assign head_data  = s_valid ? s_data : q_data;
  assign head_idx   = s_valid ? s_idx  : q_idx;
  assign head_bank  = s_valid ? s_bank : q_bank;
  assign pop        = head_valid && bus.out_ready;
  assign pop_last   = pop && (head_idx == LAST);

  // A read may only be issued if the skid buffer still has room after this pop.
  assign can_issue  = !(s_valid && q_valid) || pop;
  assign avail      = bank_full & ~issued;
  assign pick       = avail[0] ? (avail[1] ? old_bank : 1'b0) : 1'b1;
  assign re         = can_issue && ((r_state == R_DRAIN) || (avail != 2'b00));
  assign rd_bank    = (r_state == R_IDLE) ? pick : rbank;
  assign rd_idx     = (r_state == R_IDLE) ? '0 : raddr;
  assign issue_done = re && (rd_idx == LAST);
  assign s_keep     = s_valid && !pop;
  assign q_keep     = q_valid && !(pop && !s_valid);

  // RAM write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[{wbank_cur, wpos}] <= bus.in_data;
    if (re) q_data <= mem[{rd_bank, rd_idx}];
  end

  // Write FSM plus bank bookkeeping shared with the reader
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state      <= W_IDLE;
      wcnt         <= '0;
      wbank        <= 1'b0;
      bank_full    <= 2'b00;
      issued       <= 2'b00;
      old_bank     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.in_start) begin
            if (free_banks != 2'b00) begin
              wbank   <= new_bank;
              wcnt    <= LOGN'(1);
              w_state <= W_CAPT;
            end else begin
              overflow_reg <= 1'b1;
            end
          end
        end
        W_CAPT: begin
          wcnt <= wcnt + LOGN'(1);
          if (wcnt == LAST) begin
            bank_full[wbank] <= 1'b1;
            if (!bank_full[~wbank]) old_bank <= wbank;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
      if (issue_done) issued[rd_bank] <= 1'b1;
      if (pop_last) begin
        bank_full[head_bank] <= 1'b0;
        issued[head_bank]    <= 1'b0;
      end
    end
  end

  // Read FSM and skid buffer; the older word always sits in the skid entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      raddr   <= '0;
      rbank   <= 1'b0;
      q_valid <= 1'b0;
      q_idx   <= '0;
      q_bank  <= 1'b0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_idx   <= '0;
      s_bank  <= 1'b0;
    end else begin
      if (re) begin
        if (r_state == R_IDLE) begin
          rbank   <= pick;
          raddr   <= LOGN'(1);
          r_state <= R_DRAIN;
        end else begin
          raddr <= raddr + LOGN'(1);
          if (raddr == LAST) r_state <= R_IDLE;
        end
        q_valid <= 1'b1;
        q_idx   <= rd_idx;
        q_bank  <= rd_bank;
        if (!s_keep) begin
          s_valid <= q_keep;
          if (q_keep) begin
            s_data <= q_data;
            s_idx  <= q_idx;
            s_bank <= q_bank;
          end
        end
      end else begin
        s_valid <= s_keep;
        q_valid <= q_keep;
      end
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_valid ? head_data : '0;
  assign bus.out_idx   = head_valid ? head_idx : '0;
  assign bus.out_last  = head_valid && (head_idx == LAST);
  assign bus.busy      = (w_state != W_IDLE) || bank_full[0] || bank_full[1];
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_ntt_sdf_unload.sv
// Directed bench for ntt_sdf_unload: one bit-reversing and one natural-order
// instance share the same stimulus.
module tb_ntt_sdf_unload;
  localparam int LOGQ = 32;
  localparam int LOGN = 3;
  localparam int N    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_start;
  logic [31:0] in_data;
  logic        out_ready;

  always #5 clk = ~clk;

  ntt_sdf_unload_if #(.LOGQ(LOGQ), .LOGN(LOGN)) bus_r ();
  ntt_sdf_unload_if #(.LOGQ(LOGQ), .LOGN(LOGN)) bus_n ();

  assign bus_r.in_start  = in_start;
  assign bus_r.in_data   = in_data;
  assign bus_r.out_ready = out_ready;
  assign bus_n.in_start  = in_start;
  assign bus_n.in_data   = in_data;
  assign bus_n.out_ready = out_ready;

  ntt_sdf_unload #(.LOGQ(LOGQ), .LOGN(LOGN), .BITREV(1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
  ntt_sdf_unload #(.LOGQ(LOGQ), .LOGN(LOGN), .BITREV(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_rev;
    logic [31:0] exp_nat;
    logic [2:0]  exp_idx;
    logic        exp_last;
  } vec_t;

  vec_t tbl [N];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [31:0] base);
    for (int k = 0; k < N; k++) begin
      in_start = (k == 0);
      in_data  = base + 32'(k);
      tick();
    end
    in_start = 1'b0;
    in_data  = '0;
  endtask

  // Writes one frame with out_ready high and checks exact latency and order on both DUTs.
  task automatic run_frame(input logic [31:0] base);
    out_ready = 1'b1;
    write_frame(base);
    chk("lat_early_r", 64'(bus_r.out_valid), 64'd0);
    chk("lat_early_n", 64'(bus_n.out_valid), 64'd0);
    tick();
    for (int i = 0; i < N; i++) begin
      chk("valid_r", 64'(bus_r.out_valid), 64'd1);
      chk("data_r", 64'(bus_r.out_data), 64'(base + tbl[i].exp_rev));
      chk("idx_r", 64'(bus_r.out_idx), 64'(tbl[i].exp_idx));
      chk("last_r", 64'(bus_r.out_last), 64'(tbl[i].exp_last));
      chk("valid_n", 64'(bus_n.out_valid), 64'd1);
      chk("data_n", 64'(bus_n.out_data), 64'(base + tbl[i].exp_nat));
      $display("xfer idx=%0d rev=%0d nat=%0d", bus_r.out_idx, bus_r.out_data, bus_n.out_data);
      tick();
    end
    chk("drained_r", 64'(bus_r.out_valid), 64'd0);
    chk("drained_n", 64'(bus_n.out_valid), 64'd0);
    chk("idle_busy", 64'(bus_r.busy), 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus_r.out_valid), 64'd0);
    chk({tag, "_data"}, 64'(bus_r.out_data), 64'd0);
    chk({tag, "_idx"}, 64'(bus_r.out_idx), 64'd0);
    chk({tag, "_last"}, 64'(bus_r.out_last), 64'd0);
    chk({tag, "_busy"}, 64'(bus_r.busy), 64'd0);
    chk({tag, "_ovf"}, 64'(bus_r.overflow), 64'd0);
    chk({tag, "_valid_n"}, 64'(bus_n.out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'd0, 32'd0, 32'd0, 3'd0, 1'b0};
    tbl[1] = '{32'd1, 32'd4, 32'd1, 3'd1, 1'b0};
    tbl[2] = '{32'd2, 32'd2, 32'd2, 3'd2, 1'b0};
    tbl[3] = '{32'd3, 32'd6, 32'd3, 3'd3, 1'b0};
    tbl[4] = '{32'd4, 32'd1, 32'd4, 3'd4, 1'b0};
    tbl[5] = '{32'd5, 32'd5, 32'd5, 3'd5, 1'b0};
    tbl[6] = '{32'd6, 32'd3, 32'd6, 3'd6, 1'b0};
    tbl[7] = '{32'd7, 32'd7, 32'd7, 3'd7, 1'b1};

    rst = 1'b1; in_start = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Single frame: bit-reversed and natural order, latency and out_last
    run_frame(32'd0);

    // Two frames back to back drain as 16 contiguous words
    fork
      begin
        write_frame(32'd0);
        write_frame(32'd10);
      end
      begin
        int w = 0;
        while (!bus_r.out_valid && w < 40) begin tick(); w++; end
        chk("t3_latency", 64'(w), 64'd9);
        for (int j = 0; j < 2 * N; j++) begin
          chk("t3_valid", 64'(bus_r.out_valid), 64'd1);
          chk("t3_data", 64'(bus_r.out_data), 64'((j >= N ? 10 : 0) + tbl[j % N].exp_rev));
          $display("xfer t3 j=%0d data=%0d", j, bus_r.out_data);
          tick();
        end
        chk("t3_end_valid", 64'(bus_r.out_valid), 64'd0);
      end
    join
    chk("t3_ovf", 64'(bus_r.overflow), 64'd0);

    // Back-pressure: three frames, third overflows, then exactly 16 words drain
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        if (f == 2 && k == 0) chk("t4_ovf_before", 64'(bus_r.overflow), 64'd0);
        in_start = (k == 0);
        in_data  = 32'(f * 10 + k);
        tick();
        if (f == 2 && k == 0) chk("t4_ovf_after", 64'(bus_r.overflow), 64'd1);
      end
    end
    in_start = 1'b0; in_data = '0;
    repeat (3) tick();
    chk("t4_busy", 64'(bus_r.busy), 64'd1);
    chk("t4_hold_valid", 64'(bus_r.out_valid), 64'd1);
    chk("t4_hold_data", 64'(bus_r.out_data), 64'd0);
    out_ready = 1'b1;
    begin
      int got = 0;
      for (int c = 0; c < 40; c++) begin
        if (bus_r.out_valid) begin
          if (got < 2 * N)
            chk("t4_data", 64'(bus_r.out_data), 64'((got >= N ? 10 : 0) + tbl[got % N].exp_rev));
          $display("xfer t4 n=%0d data=%0d", got, bus_r.out_data);
          got++;
        end
        tick();
      end
      chk("t4_count", 64'(got), 64'd16);
    end
    chk("t4_ovf_sticky", 64'(bus_r.overflow), 64'd1);

    // Random back-pressure across two frames: no loss, no duplication, stable when stalled
    fork
      begin
        write_frame(32'd30);
        write_frame(32'd40);
      end
      begin
        int          got = 0;
        bit          pstall = 1'b0;
        logic [31:0] pd = '0;
        logic [2:0]  pi = '0;
        for (int c = 0; c < 300 && got < 2 * N; c++) begin
          bit r;
          if (pstall) begin
            chk("t5_stall_valid", 64'(bus_r.out_valid), 64'd1);
            chk("t5_stall_data", 64'(bus_r.out_data), 64'(pd));
            chk("t5_stall_idx", 64'(bus_r.out_idx), 64'(pi));
          end
          r = 1'($urandom_range(0, 1));
          out_ready = r;
          if (bus_r.out_valid && r) begin
            chk("t5_data", 64'(bus_r.out_data), 64'((got >= N ? 40 : 30) + tbl[got % N].exp_rev));
            chk("t5_idx", 64'(bus_r.out_idx), 64'(got % N));
            $display("xfer t5 n=%0d data=%0d", got, bus_r.out_data);
            got++;
          end
          pstall = bus_r.out_valid && !r;
          pd     = bus_r.out_data;
          pi     = bus_r.out_idx;
          tick();
        end
        chk("t5_count", 64'(got), 64'd16);
        chk("t5_no_dup", 64'(bus_r.out_valid), 64'd0);
      end
    join
    out_ready = 1'b1;
    tick();

    // Reset in the middle of a capture
    in_start = 1'b1; in_data = 32'd50; tick();
    in_start = 1'b0;
    for (int k = 1; k < 4; k++) begin in_data = 32'(50 + k); tick(); end
    chk("t6_busy_pre", 64'(bus_r.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("t6_wr_rst");
    tick();
    rst = 1'b0; in_data = '0;
    repeat (6) tick();
    chk("t6_quiet", 64'(bus_r.out_valid), 64'd0);
    run_frame(32'd60);

    // Reset in the middle of a drain
    write_frame(32'd70);
    repeat (4) tick();
    chk("t6_mid_valid", 64'(bus_r.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("t6_rd_rst");
    tick();
    rst = 1'b0;
    run_frame(32'd80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
